// File: rtl/riscv_wb_scheduler_pkg.sv
// Shared constants and types for the write-back scheduler slice.
// Register count defaults to `REG_COUNT (32) unless it is defined before this file.
// Requester IDs index the one-hot grant vector: WB_REQ_ALU = 0 and WB_REQ_MEM = 1.
`ifndef REG_COUNT
`define REG_COUNT 32
`endif

package riscv_wb_scheduler_pkg;
  localparam int   REG_COUNT_DEF = `REG_COUNT;
  localparam int   IDX_W         = 5;
  localparam int   XLEN          = 32;
  localparam logic WB_REQ_ALU    = 1'b0;
  localparam logic WB_REQ_MEM    = 1'b1;

  // One write-back request: destination index plus result data.
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [XLEN-1:0]  dat;
  } wb_req_t;
endpackage

// File: rtl/riscv_rr_arbiter2.sv
// riscv_rr_arbiter2: two-input round-robin arbiter with its last-grant pointer.
// Latency: the grant is combinational from req_i and the pointer; the pointer moves on the next edge.
// Backpressure: a loser keeps requesting and wins the next tie; the pointer only moves when something is granted.
module riscv_rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);
  // last_q = 1 means requester 1 won last, so requester 0 wins the next tie.
  logic last_q, last_d;

  // Single requester always wins; on a tie the one not granted last wins.
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_q ? 2'b01 : 2'b10;
    end
  end

  // Pointer follows the winner, but only on cycles that actually grant.
  always_comb begin
    last_d = last_q;
    if (advance_i && (gnt_o != 2'b00)) begin
      last_d = gnt_o[1];
    end
  end

  // Reset points at requester 1 so requester 0 takes the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= 1'b1;
    else         last_q <= last_d;
  end
endmodule

// File: rtl/riscv_wb_scheduler.sv
// riscv_wb_scheduler: shares the regfile write port between ALU and LSU and keeps a per-register busy scoreboard.
// Latency: grant and write port are combinational from valid; busy bits and the stale flag update on the next edge.
// Backpressure: a requester holds valid/index/data until it sees ready; RISCV_WB_BYPASS_EN adds same-cycle forwarding.
module riscv_wb_scheduler
  import riscv_wb_scheduler_pkg::*;
#(
  parameter int REG_COUNT = REG_COUNT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd_index,
  input  logic [31:0] alu_rd,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd_index,
  input  logic [31:0] mem_rd,
  output logic        rf_enable_write_rd,
  output logic [4:0]  rf_rd_index,
  output logic [31:0] rf_rd,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd_index,
  input  logic [4:0]  rs1_index,
  input  logic [4:0]  rs2_index,
  input  logic [4:0]  rd_index,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        rd_busy,
  output logic [31:0] rs1_fwd,
  output logic [31:0] rs2_fwd,
  output logic        rs1_fwd_valid,
  output logic        rs2_fwd_valid,
  output logic        stale_write_err
);
  logic [1:0]  gnt;
  wb_req_t     alu_req, mem_req, wr_req;
  logic        wr_en;
  logic [31:0] busy_q, busy_d;
  logic        err_q, err_d;
  logic        rs1_hit, rs2_hit;

  // x0 and indices beyond the register file are never tracked.
  function automatic logic tracked(input logic [4:0] idx);
    return (idx != 5'd0) && (int'(idx) < REG_COUNT);
  endfunction

  assign alu_req = {alu_rd_index, alu_rd};
  assign mem_req = {mem_rd_index, mem_rd};

  riscv_rr_arbiter2 u_arb (
    .clk_i     (clock),
    .rst_ni    (reset),
    .req_i     ({mem_valid, alu_valid}),
    .advance_i (alu_valid | mem_valid),
    .gnt_o     (gnt)
  );

  assign alu_ready = gnt[WB_REQ_ALU];
  assign mem_ready = gnt[WB_REQ_MEM];

  // Write-port mux: idle port presents all zeros.
  always_comb begin
    wr_req = '0;
    if (gnt[WB_REQ_ALU])      wr_req = alu_req;
    else if (gnt[WB_REQ_MEM]) wr_req = mem_req;
  end

  assign wr_en              = (gnt != 2'b00) && (wr_req.idx != 5'd0);
  assign rf_enable_write_rd = wr_en;
  assign rf_rd_index        = wr_req.idx;
  assign rf_rd              = wr_req.dat;

  // Scoreboard next state: a write clears, an issue sets, and the set is applied last so it wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[wr_req.idx] = 1'b0;
    if (issue_valid && tracked(issue_rd_index)) busy_d[issue_rd_index] = 1'b1;
  end

  // A write to a register with no pending issue is flagged; the write itself still goes ahead.
  assign err_d = err_q | (wr_en && !busy_q[wr_req.idx]);

  // Scoreboard and sticky error register, both cleared straight away by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign stale_write_err = err_q;

`ifdef RISCV_WB_BYPASS_EN
  // The value being written this cycle is forwarded, so the source no longer needs to wait.
  assign rs1_hit = wr_en && (wr_req.idx == rs1_index);
  assign rs2_hit = wr_en && (wr_req.idx == rs2_index);
  assign rs1_fwd_valid = rs1_hit;
  assign rs2_fwd_valid = rs2_hit;
  assign rs1_fwd = rs1_hit ? wr_req.dat : 32'd0;
  assign rs2_fwd = rs2_hit ? wr_req.dat : 32'd0;
`else
  assign rs1_hit = 1'b0;
  assign rs2_hit = 1'b0;
  assign rs1_fwd_valid = 1'b0;
  assign rs2_fwd_valid = 1'b0;
  assign rs1_fwd = 32'd0;
  assign rs2_fwd = 32'd0;
`endif

  // Bit 0 is never set, so x0 queries read 0 without special casing.
  assign rs1_busy = busy_q[rs1_index] & ~rs1_hit;
  assign rs2_busy = busy_q[rs2_index] & ~rs2_hit;
  assign rd_busy  = busy_q[rd_index];
endmodule

// File: tb/tb_riscv_wb_scheduler.sv
// Bench for riscv_wb_scheduler: directed scenarios plus a randomized phase.
// Requests push expected writes into per-requester queues; a negedge monitor pops them on ready.
// Busy, stale and grant expectations come from a simple behavioural model of the scheduler.
module tb_riscv_wb_scheduler;
  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, issue_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_rd_index, mem_rd_index, issue_rd_index;
  logic [31:0] alu_rd, mem_rd;
  logic        rf_enable_write_rd;
  logic [4:0]  rf_rd_index;
  logic [31:0] rf_rd;
  logic [4:0]  rs1_index, rs2_index, rd_index;
  logic        rs1_busy, rs2_busy, rd_busy;
  logic [31:0] rs1_fwd, rs2_fwd;
  logic        rs1_fwd_valid, rs2_fwd_valid;
  logic        stale_write_err;

  always #5 clock = ~clock;

  riscv_wb_scheduler dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd_index(alu_rd_index), .alu_rd(alu_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd_index(mem_rd_index), .mem_rd(mem_rd),
    .rf_enable_write_rd(rf_enable_write_rd), .rf_rd_index(rf_rd_index), .rf_rd(rf_rd),
    .issue_valid(issue_valid), .issue_rd_index(issue_rd_index),
    .rs1_index(rs1_index), .rs2_index(rs2_index), .rd_index(rd_index),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
    .rs1_fwd_valid(rs1_fwd_valid), .rs2_fwd_valid(rs2_fwd_valid),
    .stale_write_err(stale_write_err)
  );

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] dat;
  } exp_t;

  exp_t alu_q[$];
  exp_t mem_q[$];
  int   total = 0;
  int   bad   = 0;

  // Behavioural model state.
  bit   mbusy[32];
  bit   claimed[32];
  bit   merr;
  bit   mlast_mem;
  bit   mon_en = 1'b0;
  bit   alu_seen, mem_seen;

  // Monitor scratch.
  bit          m_ea, m_em, m_wvld, m_wen, h1, h2;
  exp_t        m_e;
  logic [4:0]  m_widx;
  logic [31:0] m_wdat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every combinational output mid-cycle, then advance the model to the next edge.
  always @(negedge clock) begin
    if (mon_en) begin
      m_ea = alu_valid && (!mem_valid || mlast_mem);
      m_em = mem_valid && !m_ea;
      chk("alu_ready", alu_ready, m_ea);
      chk("mem_ready", mem_ready, m_em);
      alu_seen = alu_ready;
      mem_seen = mem_ready;

      m_wvld = 1'b0;
      m_e    = '0;
      if (m_ea && alu_q.size() > 0) begin m_e = alu_q[0]; m_wvld = 1'b1; end
      else if (m_em && mem_q.size() > 0) begin m_e = mem_q[0]; m_wvld = 1'b1; end
      m_wen  = m_wvld && (m_e.idx != 5'd0);
      m_widx = m_wvld ? m_e.idx : 5'd0;
      m_wdat = m_wvld ? m_e.dat : 32'd0;
      chk("rf_we", rf_enable_write_rd, m_wen);
      chk("rf_idx", rf_rd_index, m_widx);
      chk("rf_dat", rf_rd, m_wdat);

      if (alu_ready) begin
        total++;
        if (alu_q.size() == 0) begin bad++; $display("FAIL alu_pop: ready with no expected write at %0t", $time); end
        else void'(alu_q.pop_front());
      end
      if (mem_ready) begin
        total++;
        if (mem_q.size() == 0) begin bad++; $display("FAIL mem_pop: ready with no expected write at %0t", $time); end
        else void'(mem_q.pop_front());
      end

`ifdef RISCV_WB_BYPASS_EN
      h1 = m_wen && (m_widx == rs1_index);
      h2 = m_wen && (m_widx == rs2_index);
`else
      h1 = 1'b0;
      h2 = 1'b0;
`endif
      chk("rs1_busy", rs1_busy, (rs1_index != 0) && mbusy[rs1_index] && !h1);
      chk("rs2_busy", rs2_busy, (rs2_index != 0) && mbusy[rs2_index] && !h2);
      chk("rd_busy", rd_busy, (rd_index != 0) && mbusy[rd_index]);
      chk("rs1_fwd_valid", rs1_fwd_valid, h1);
      chk("rs2_fwd_valid", rs2_fwd_valid, h2);
      chk("rs1_fwd", rs1_fwd, h1 ? m_wdat : 32'd0);
      chk("rs2_fwd", rs2_fwd, h2 ? m_wdat : 32'd0);
      chk("stale_err", stale_write_err, merr);

      if (m_wen && !mbusy[m_widx]) merr = 1'b1;
      if (m_wen) mbusy[m_widx] = 1'b0;
      if (issue_valid && issue_rd_index != 0) mbusy[issue_rd_index] = 1'b1;
      if (m_ea || m_em) mlast_mem = m_em;
    end
  end

  // Advance one cycle: drop one-shot issue, retire requests the DUT accepted.
  task automatic tick();
    @(posedge clock);
    #1;
    issue_valid    = 1'b0;
    issue_rd_index = 5'd0;
    if (alu_valid && alu_seen) begin alu_valid = 1'b0; claimed[alu_rd_index] = 1'b0; end
    if (mem_valid && mem_seen) begin mem_valid = 1'b0; claimed[mem_rd_index] = 1'b0; end
    alu_seen = 1'b0;
    mem_seen = 1'b0;
  endtask

  task automatic start_alu(input logic [4:0] idx, input logic [31:0] dat);
    alu_valid = 1'b1; alu_rd_index = idx; alu_rd = dat;
    alu_q.push_back({idx, dat});
    if (idx != 0) claimed[idx] = 1'b1;
  endtask

  task automatic start_mem(input logic [4:0] idx, input logic [31:0] dat);
    mem_valid = 1'b1; mem_rd_index = idx; mem_rd = dat;
    mem_q.push_back({idx, dat});
    if (idx != 0) claimed[idx] = 1'b1;
  endtask

  task automatic issue_one(input logic [4:0] idx);
    issue_valid = 1'b1; issue_rd_index = idx;
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (alu_valid || mem_valid); i++) tick();
    total++;
    if (alu_valid || mem_valid) begin
      bad++;
      $display("FAIL drain: requests still pending alu=%0b mem=%0b", alu_valid, mem_valid);
    end
  endtask

  // Pick a register with a pending issue that no requester is writing yet.
  task automatic pick_busy(output logic [4:0] idx, output bit ok);
    ok = 1'b0; idx = 5'd0;
    if ($urandom_range(7, 0) == 0) begin ok = 1'b1; return; end
    for (int t = 0; t < 8 && !ok; t++) begin
      idx = 5'($urandom_range(31, 1));
      if (mbusy[idx] && !claimed[idx]) ok = 1'b1;
    end
  endtask

  task automatic pick_free(output logic [4:0] idx, output bit ok);
    ok = 1'b0; idx = 5'd0;
    if ($urandom_range(9, 0) == 0) begin ok = 1'b1; return; end
    for (int t = 0; t < 8 && !ok; t++) begin
      idx = 5'($urandom_range(31, 1));
      if (!mbusy[idx] && !claimed[idx]) ok = 1'b1;
    end
  endtask

  task automatic model_clear();
    alu_q.delete(); mem_q.delete();
    for (int i = 0; i < 32; i++) begin mbusy[i] = 1'b0; claimed[i] = 1'b0; end
    merr = 1'b0; mlast_mem = 1'b1; alu_seen = 1'b0; mem_seen = 1'b0;
    alu_valid = 0; mem_valid = 0; issue_valid = 0;
    alu_rd_index = 0; mem_rd_index = 0; issue_rd_index = 0; alu_rd = 0; mem_rd = 0;
    rs1_index = 0; rs2_index = 0; rd_index = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] r;
    bit         ok;
    bit         prev_alu;
    int         ai, mi;
    logic [4:0] alist [2];
    logic [4:0] mlist [3];

    model_clear();
    reset = 1'b0;
    rs1_index = 5'd5; rd_index = 5'd5;
    #2;
    chk("rst_alu_ready", alu_ready, 1'b0);
    chk("rst_rf_we", rf_enable_write_rd, 1'b0);
    chk("rst_rs1_busy", rs1_busy, 1'b0);
    chk("rst_err", stale_write_err, 1'b0);
    #10;
    reset = 1'b1;
    mon_en = 1'b1;
    tick();

    // ALU only: x5 issued, then written one cycle later.
    rs1_index = 5'd5;
    issue_one(5'd5);
    start_alu(5'd5, 32'h1234);
    #1;
    chk("t1_alu_ready", alu_ready, 1'b1);
    chk("t1_rf_dat", rf_rd, 32'h1234);
`ifdef RISCV_WB_BYPASS_EN
    chk("t1_rs1_busy", rs1_busy, 1'b0);
`else
    chk("t1_rs1_busy", rs1_busy, 1'b1);
`endif
    tick();
    #1;
    chk("t1_rs1_clear", rs1_busy, 1'b0);

    // Contention: both requesters keep a request up; grants must alternate.
    alist[0] = 5'd3;  alist[1] = 5'd13;
    mlist[0] = 5'd4;  mlist[1] = 5'd14; mlist[2] = 5'd15;
    issue_one(5'd3); issue_one(5'd13); issue_one(5'd4); issue_one(5'd14); issue_one(5'd15);
    start_alu(alist[0], 32'hA000_0003); ai = 1;
    start_mem(mlist[0], 32'hB000_0004); mi = 1;
    #1;
    prev_alu = alu_ready;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (!alu_valid && ai < 2) begin start_alu(alist[ai], 32'hA000_0000 | 32'(alist[ai])); ai++; end
      if (!mem_valid && mi < 3) begin start_mem(mlist[mi], 32'hB000_0000 | 32'(mlist[mi])); mi++; end
      #1;
      chk("contend_alt", alu_ready, !prev_alu);
      prev_alu = alu_ready;
    end
    drain();

    // Set wins: issue x7 in the same cycle as the write to x7.
    issue_one(5'd7);
    start_alu(5'd7, 32'h7777);
    issue_valid = 1'b1; issue_rd_index = 5'd7;
    tick();
    rs1_index = 5'd7;
    #1;
    chk("setwins_busy", rs1_busy, 1'b1);
    start_mem(5'd7, 32'h7778);
    drain();

    // x0: issue ignored, write not enabled, no error.
    rd_index = 5'd0;
    issue_one(5'd0);
    start_alu(5'd0, 32'hDEAD);
    #1;
    chk("x0_ready", alu_ready, 1'b1);
    chk("x0_we", rf_enable_write_rd, 1'b0);
    tick();
    chk("x0_err", stale_write_err, 1'b0);

    // Randomized traffic respecting the issue contract.
    for (int c = 0; c < 2500; c++) begin
      if (!alu_valid && $urandom_range(1, 0) == 1) begin
        pick_busy(r, ok);
        if (ok) start_alu(r, $urandom);
      end
      if (!mem_valid && $urandom_range(1, 0) == 1) begin
        pick_busy(r, ok);
        if (ok) start_mem(r, $urandom);
      end
      if ($urandom_range(2, 0) == 0) begin
        pick_free(r, ok);
        if (ok) begin issue_valid = 1'b1; issue_rd_index = r; end
      end
      rs1_index = ($urandom_range(2, 0) == 0) ? alu_rd_index : 5'($urandom_range(31, 0));
      rs2_index = ($urandom_range(2, 0) == 0) ? mem_rd_index : 5'($urandom_range(31, 0));
      rd_index  = 5'($urandom_range(31, 0));
      tick();
    end
    drain();

    // Stale write: LSU writes a register with no pending issue.
    r = 5'd9;
    for (int t = 1; t < 32 && mbusy[r]; t++) r = 5'(t);
    start_mem(r, 32'h0909);
    tick();
    #1;
    chk("stale_set", stale_write_err, 1'b1);
    repeat (3) tick();
    chk("stale_sticky", stale_write_err, 1'b1);

    // Reset mid-cycle with a busy register and a pending request.
    issue_one(5'd11);
    rs1_index = 5'd11; rd_index = 5'd11;
    start_alu(5'd20, 32'h2020);
    #1;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    chk("midrst_rs1_busy", rs1_busy, 1'b0);
    chk("midrst_rd_busy", rd_busy, 1'b0);
    chk("midrst_err", stale_write_err, 1'b0);
    model_clear();
    @(posedge clock);
    #2;
    reset  = 1'b1;
    mon_en = 1'b1;

    // Post-reset: ALU wins the first tie again.
    issue_one(5'd21); issue_one(5'd22);
    start_alu(5'd21, 32'h2121);
    start_mem(5'd22, 32'h2222);
    #1;
    chk("postrst_tie", alu_ready, 1'b1);
    drain();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
